// File: rtl/life_sequencer.sv
// Generation sequencer for the Game of Life cell array: run/stop/step/clear
// control, programmable generation period, generation counter and auto-halt.
module life_sequencer #(
    parameter int TICK_BASE = 4,
    parameter int GEN_W     = 16,
    parameter int CNT_W     = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic [3:0]       speed,
    input  logic             alive_any,
    input  logic             changed,
    output logic             cell_pause,
    output logic             cell_clear,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_ADV_RUN  = 3'd2,
        S_ADV_STEP = 3'd3,
        S_CLEAR    = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    // Terminal tick value P-2 for a given rate select, P = (speed+1)*TICK_BASE.
    function automatic logic [CNT_W-1:0] term_of(input logic [3:0] spd);
        logic [31:0] full_v;
        full_v = ({28'd0, spd} + 32'd1) * 32'(TICK_BASE) - 32'd2;
        return full_v[CNT_W-1:0];
    endfunction

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] tick_r, tick_next_s;
    logic [CNT_W-1:0] term_r, term_next_s;
    logic [GEN_W-1:0] gen_r;
    logic             start_prev_r, stop_prev_r, step_prev_r, clear_prev_r;
    logic             start_p_s, stop_p_s, step_p_s, clear_p_s;
    logic             cell_pause_r, cell_clear_r, running_r, halted_r;

    assign start_p_s = start & ~start_prev_r;
    assign stop_p_s  = stop  & ~stop_prev_r;
    assign step_p_s  = step  & ~step_prev_r;
    assign clear_p_s = clear & ~clear_prev_r;

    // Input history for rising-edge press detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            start_prev_r <= 1'b0;
            stop_prev_r  <= 1'b0;
            step_prev_r  <= 1'b0;
            clear_prev_r <= 1'b0;
        end else begin
            start_prev_r <= start;
            stop_prev_r  <= stop;
            step_prev_r  <= step;
            clear_prev_r <= clear;
        end
    end

    // Next-state, tick counter and period latch decode.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        term_next_s  = term_r;
        case (state_r)
            S_IDLE, S_HALT: begin
                if (clear_p_s) begin
                    state_next_s = S_CLEAR;
                end else if (step_p_s) begin
                    state_next_s = S_ADV_STEP;
                end else if (start_p_s) begin
                    state_next_s = S_WAIT;
                    tick_next_s  = '0;
                    term_next_s  = term_of(speed);
                end else begin
                    state_next_s = state_r;
                end
            end
            S_WAIT: begin
                if (clear_p_s) begin
                    state_next_s = S_CLEAR;
                end else if (stop_p_s) begin
                    state_next_s = S_IDLE;
                end else if (tick_r == term_r) begin
                    // Empty grid or still life: nothing left to advance.
                    if (!alive_any || !changed) begin
                        state_next_s = S_HALT;
                    end else begin
                        state_next_s = S_ADV_RUN;
                    end
                end else begin
                    tick_next_s = tick_r + CNT_W'(1);
                end
            end
            S_ADV_RUN: begin
                if (clear_p_s) begin
                    state_next_s = S_CLEAR;
                end else if (stop_p_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT;
                    tick_next_s  = '0;
                    term_next_s  = term_of(speed);
                end
            end
            S_ADV_STEP: begin
                if (clear_p_s) begin
                    state_next_s = S_CLEAR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, counters and Moore outputs registered from the next state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= S_IDLE;
            tick_r       <= '0;
            term_r       <= '0;
            gen_r        <= '0;
            cell_pause_r <= 1'b1;
            cell_clear_r <= 1'b0;
            running_r    <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
            term_r  <= term_next_s;
            if ((state_r == S_ADV_RUN) || (state_r == S_ADV_STEP)) begin
                gen_r <= gen_r + GEN_W'(1);
            end else if (state_r == S_CLEAR) begin
                gen_r <= '0;
            end else begin
                gen_r <= gen_r;
            end
            cell_pause_r <= !((state_next_s == S_ADV_RUN) || (state_next_s == S_ADV_STEP));
            cell_clear_r <= (state_next_s == S_CLEAR);
            running_r    <= (state_next_s == S_WAIT) || (state_next_s == S_ADV_RUN);
            halted_r     <= (state_next_s == S_HALT);
        end
    end

    assign cell_pause = cell_pause_r;
    assign cell_clear = cell_clear_r;
    assign gen_count  = gen_r;
    assign running    = running_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: expected advance cycles and generation
// values are queued at stimulus time and consumed whenever cell_pause drops.
module tb_life_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step = 1'b0, clear = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        alive_any = 1'b1, changed = 1'b1;
    logic        cell_pause, cell_clear, running, halted;
    logic [15:0] gen_count;
    logic        cell_pause4, cell_clear4, running4, halted4;
    logic [3:0]  gen4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_gen = 0;

    typedef struct {
        int cyc;
        int gen;
    } exp_t;
    exp_t sb_q[$];

    life_sequencer #(.TICK_BASE(4), .GEN_W(16), .CNT_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .speed(speed), .alive_any(alive_any), .changed(changed),
        .cell_pause(cell_pause), .cell_clear(cell_clear), .gen_count(gen_count),
        .running(running), .halted(halted)
    );

    life_sequencer #(.TICK_BASE(4), .GEN_W(4), .CNT_W(8)) dut4 (
        .Clock(Clock), .Reset(Reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .speed(speed), .alive_any(alive_any), .changed(changed),
        .cell_pause(cell_pause4), .cell_clear(cell_clear4), .gen_count(gen4),
        .running(running4), .halted(halted4)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard consumer: every low cell_pause cycle must match a queued advance.
    always @(negedge Clock) begin : sb_mon
        exp_t e;
        if (Reset && cell_pause === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_advance cyc=%0d gen=%0d", cyc, gen_count);
            end else begin
                e = sb_q.pop_front();
                if (cyc !== e.cyc || gen_count !== e.gen[15:0] || gen4 !== e.gen[3:0]) begin
                    failures++;
                    $display("FAIL advance cyc=%0d gen=%0d gen4=%0d required cyc=%0d gen=%0d",
                             cyc, gen_count, gen4, e.cyc, e.gen);
                end
            end
        end
    end

    function automatic void expect_adv(input int c);
        sb_q.push_back('{c, exp_gen});
        exp_gen++;
    endfunction

    task automatic goto(input int t);
        repeat (t - cyc) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if (cell_pause !== 1'b1 || cell_clear !== 1'b0 || running !== 1'b0 ||
            halted !== 1'b0 || gen_count !== 16'd0) begin
            failures++;
            $display("FAIL reset pause=%b clr=%b run=%b halt=%b gen=%0d required 1 0 0 0 0",
                     cell_pause, cell_clear, running, halted, gen_count);
        end
        Reset = 1'b1;
    endtask

    task automatic test_run(input int spd, input int n);
        int c, p;
        bit bad;
        p = (spd + 1) * 4;
        bad = 1'b0;
        @(negedge Clock);
        c = cyc;
        speed = 4'(spd);
        start = 1'b1;
        for (int i = 1; i <= n; i++) expect_adv(c + i * p);
        for (int k = 1; k <= n * p; k++) begin
            @(negedge Clock);
            if (k == 2) start = 1'b0;
            if (running !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL run_running speed=%0d observed a low running, required 1", spd);
        end
        @(negedge Clock);
        stop = 1'b1;
        @(negedge Clock);
        stop = 1'b0;
        checks++;
        if (running !== 1'b0 || halted !== 1'b0 || gen_count !== 16'(exp_gen)) begin
            failures++;
            $display("FAIL run_stop run=%b halt=%b gen=%0d required 0 0 %0d",
                     running, halted, gen_count, exp_gen);
        end
        goto(cyc + 2 * p);
    endtask

    task automatic test_step();
        int c;
        @(negedge Clock);
        c = cyc;
        step = 1'b1;
        expect_adv(c + 1);
        goto(c + 5);
        step = 1'b0;
        goto(c + 10);
        step = 1'b1;
        expect_adv(c + 11);
        goto(c + 15);
        step = 1'b0;
        goto(c + 18);
        checks++;
        if (running !== 1'b0 || halted !== 1'b0 || cell_pause !== 1'b1 ||
            gen_count !== 16'(exp_gen)) begin
            failures++;
            $display("FAIL step_idle run=%b halt=%b pause=%b gen=%0d required 0 0 1 %0d",
                     running, halted, cell_pause, gen_count, exp_gen);
        end
    endtask

    task automatic test_halt();
        int c;
        @(negedge Clock);
        c = cyc;
        speed = 4'd0;
        changed = 1'b1;
        start = 1'b1;
        expect_adv(c + 4);
        goto(c + 1);
        start = 1'b0;
        goto(c + 6);
        changed = 1'b0;
        goto(c + 8);
        checks++;
        if (halted !== 1'b1 || cell_pause !== 1'b1 || running !== 1'b0 ||
            gen_count !== 16'(exp_gen)) begin
            failures++;
            $display("FAIL halt_enter halt=%b pause=%b run=%b gen=%0d required 1 1 0 %0d",
                     halted, cell_pause, running, gen_count, exp_gen);
        end
        goto(c + 12);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold halt=%b required 1", halted);
        end
        step = 1'b1;
        expect_adv(c + 13);
        goto(c + 13);
        step = 1'b0;
        goto(c + 14);
        checks++;
        if (halted !== 1'b0 || running !== 1'b0 || gen_count !== 16'(exp_gen)) begin
            failures++;
            $display("FAIL halt_step halt=%b run=%b gen=%0d required 0 0 %0d",
                     halted, running, gen_count, exp_gen);
        end
        start = 1'b1;
        goto(c + 15);
        start = 1'b0;
        goto(c + 18);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_again halt=%b required 1", halted);
        end
        changed = 1'b1;
        start = 1'b1;
        expect_adv(c + 22);
        goto(c + 19);
        start = 1'b0;
        checks++;
        if (halted !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL halt_resume halt=%b run=%b required 0 1", halted, running);
        end
        goto(c + 23);
        stop = 1'b1;
        goto(c + 24);
        stop = 1'b0;
        checks++;
        if (running !== 1'b0 || gen_count !== 16'(exp_gen)) begin
            failures++;
            $display("FAIL halt_stop run=%b gen=%0d required 0 %0d", running, gen_count, exp_gen);
        end
    endtask

    task automatic test_clear_wins();
        int c;
        @(negedge Clock);
        c = cyc;
        speed = 4'd3;
        start = 1'b1;
        goto(c + 1);
        start = 1'b0;
        goto(c + 3);
        clear = 1'b1;
        step = 1'b1;
        goto(c + 4);
        clear = 1'b0;
        step = 1'b0;
        checks++;
        if (cell_clear !== 1'b1 || cell_pause !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL clear_cycle clr=%b pause=%b run=%b required 1 1 0",
                     cell_clear, cell_pause, running);
        end
        exp_gen = 0;
        goto(c + 5);
        checks++;
        if (cell_clear !== 1'b0 || gen_count !== 16'd0 || gen4 !== 4'd0 ||
            running !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL clear_after clr=%b gen=%0d gen4=%0d run=%b halt=%b required 0 0 0 0 0",
                     cell_clear, gen_count, gen4, running, halted);
        end
        goto(c + 24);
    endtask

    task automatic test_wrap_and_reset();
        int c;
        @(negedge Clock);
        c = cyc;
        speed = 4'd0;
        start = 1'b1;
        for (int i = 1; i <= 18; i++) expect_adv(c + 4 * i);
        goto(c + 1);
        start = 1'b0;
        goto(c + 16 * 4 + 1);
        checks++;
        if (gen4 !== 4'd0 || gen_count !== 16'd16) begin
            failures++;
            $display("FAIL wrap_zero gen4=%0d gen=%0d required 0 16", gen4, gen_count);
        end
        goto(c + 17 * 4 + 1);
        checks++;
        if (gen4 !== 4'd1 || gen_count !== 16'd17) begin
            failures++;
            $display("FAIL wrap_one gen4=%0d gen=%0d required 1 17", gen4, gen_count);
        end
        goto(c + 18 * 4);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (cell_pause !== 1'b1 || cell_clear !== 1'b0 || running !== 1'b0 ||
            halted !== 1'b0 || gen_count !== 16'd0 || gen4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_adv pause=%b clr=%b run=%b halt=%b gen=%0d gen4=%0d required 1 0 0 0 0 0",
                     cell_pause, cell_clear, running, halted, gen_count, gen4);
        end
        exp_gen = 0;
        @(negedge Clock);
        Reset = 1'b1;
        goto(cyc + 10);
        checks++;
        if (running !== 1'b0 || gen_count !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_idle run=%b gen=%0d required 0 0", running, gen_count);
        end
    endtask

    initial begin
        test_reset();
        test_run(0, 3);
        test_run(3, 3);
        test_step();
        test_halt();
        test_clear_wins();
        test_wrap_and_reset();
        repeat (2) @(negedge Clock);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL missing_advances pending=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
